dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane writes plus a small MMIO block
// (console FIFO, free-running cycle counter, tohost mailbox, status/overflow control).
module dmem_responder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DADDR   = 16,
  parameter int unsigned RAM_AW  = 12,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic [3:0]       dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic [7:0]       con_data,
  output logic             con_valid,
  input  logic             con_ready,
  output logic             tohost_valid,
  output logic [WIDTH-1:0] tohost_data
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned LANES      = 4;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_CYCLE   = 2'd1;
  localparam logic [1:0] OFF_TOHOST  = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // Address decode; byte offset and upper alias bits are don't-care.
  logic              is_mmio;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_off;
  logic              any_wr;
  logic              unused_addr;

  assign is_mmio     = dmem_addr[DADDR-1];
  assign ram_idx     = dmem_addr[RAM_AW+1:2];
  assign mmio_off    = dmem_addr[3:2];
  assign any_wr      = |dmem_wr_en;
  assign unused_addr = ^{dmem_addr[1:0], dmem_addr[DADDR-2:RAM_AW+2]};

  // Expand per-byte enables into a bit mask over the data word.
  logic [WIDTH-1:0] lane_mask;
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[8*i +: 8] = {8{dmem_wr_en[i]}};
    end
  end

  // RAM: combinational read, lane-masked synchronous write, never reset.
  logic [WIDTH-1:0] ram [RAM_DEPTH];
  logic             ram_we;

  assign ram_we = !is_mmio && any_wr;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= (ram[ram_idx] & ~lane_mask) | (dmem_wdata & lane_mask);
    end
  end

  // Console FIFO control.
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               full;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               ovf_clr;
  logic               tohost_we;

  assign con_valid = (count != '0);
  assign con_data  = fifo_mem[rd_ptr];
  assign full      = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop       = con_valid && con_ready;
  assign push_req  = is_mmio && (mmio_off == OFF_CONSOLE) && dmem_wr_en[0];
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_clr   = is_mmio && (mmio_off == OFF_STATUS) && dmem_wr_en[0] && dmem_wdata[0];
  assign tohost_we = is_mmio && (mmio_off == OFF_TOHOST) && any_wr;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= dmem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set by a dropped push, cleared only by software or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Free-running cycle counter.
  logic [WIDTH-1:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + WIDTH'(1);
    end
  end

  // Tohost mailbox; the valid flag stays set until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (tohost_we) begin
      tohost_valid <= 1'b1;
      tohost_data  <= (tohost_data & ~lane_mask) | (dmem_wdata & lane_mask);
    end
  end

  // Read data mux.
  always_comb begin
    dmem_rdata = '0;
    if (!is_mmio) begin
      dmem_rdata = ram[ram_idx];
    end else begin
      case (mmio_off)
        OFF_CONSOLE: dmem_rdata = WIDTH'({overflow, 23'b0, full, 7'(count)});
        OFF_CYCLE:   dmem_rdata = cycle_cnt;
        OFF_TOHOST:  dmem_rdata = tohost_data;
        OFF_STATUS:  dmem_rdata = WIDTH'({tohost_valid, con_valid});
        default:     dmem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// queue/associative-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wr_en;
  logic [31:0] dmem_rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  dmem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_rdata   (dmem_rdata),
    .con_data     (con_data),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] ram_m [int];
  logic [7:0]  q [$];
  bit          ovf_m;
  logic [31:0] cyc_m;
  logic [31:0] th_data_m;
  bit          th_valid_m;

  // Values observed in the most recent cycle.
  logic [31:0] obs_rd;
  logic        obs_cv;
  logic [7:0]  obs_cd;
  logic        obs_tv;
  logic [31:0] obs_td;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  function automatic bit exp_read(input logic [15:0] a, output logic [31:0] v);
    int w;
    int sz;
    v  = '0;
    sz = q.size();
    if (a[15] == 1'b0) begin
      w = (int'(a) >> 2) % 4096;
      if (!ram_m.exists(w)) return 1'b0;
      v = ram_m[w];
      return 1'b1;
    end
    case ((int'(a) >> 2) % 4)
      0: v = (ovf_m ? 32'h8000_0000 : 32'h0) + (sz == 8 ? 32'd128 : 32'd0) + 32'(sz);
      1: v = cyc_m;
      2: v = th_data_m;
      default: v = (th_valid_m ? 32'd2 : 32'd0) + (sz != 0 ? 32'd1 : 32'd0);
    endcase
    return 1'b1;
  endfunction

  // One bus cycle: starts and ends at a falling edge.
  task automatic cycle(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic rdy);
    logic [31:0] e;
    bit          mmio;
    int          off;
    int          w;
    bit          do_pop;
    bit          was_full;
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_wr_en = we;
    con_ready  = rdy;
    #1;
    obs_rd = dmem_rdata;
    obs_cv = con_valid;
    obs_cd = con_data;
    obs_tv = tohost_valid;
    obs_td = tohost_data;
    if (exp_read(a, e)) check("rdata", dmem_rdata, e);
    check("con_valid", 32'(con_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("con_data", 32'(con_data), 32'(q[0]));
    check("th_valid", 32'(tohost_valid), 32'(th_valid_m));
    check("th_data", tohost_data, th_data_m);
    @(posedge clk);
    mmio     = a[15];
    off      = (int'(a) >> 2) % 4;
    do_pop   = (q.size() != 0) && rdy;
    was_full = (q.size() == 8);
    if (do_pop) void'(q.pop_front());
    if (mmio && off == 0 && we[0]) begin
      if (!was_full || do_pop) q.push_back(wd[7:0]);
      else ovf_m = 1'b1;
    end
    if (mmio && off == 3 && we[0] && wd[0]) ovf_m = 1'b0;
    if (mmio && off == 2 && we != 4'b0) begin
      th_data_m  = merge(th_data_m, wd, we);
      th_valid_m = 1'b1;
    end
    if (!mmio && we != 4'b0) begin
      w = (int'(a) >> 2) % 4096;
      if (ram_m.exists(w)) ram_m[w] = merge(ram_m[w], wd, we);
      else if (we == 4'hF) ram_m[w] = wd;
    end
    cyc_m = cyc_m + 32'd1;
    @(negedge clk);
  endtask

  // Reset pulse with an MMIO write held on the bus; starts and ends at a falling edge.
  task automatic do_reset(input int n);
    reset_n    = 1'b0;
    dmem_addr  = 16'h8000;
    dmem_wdata = 32'h55;
    dmem_wr_en = 4'b0001;
    con_ready  = 1'b0;
    q.delete();
    ovf_m      = 1'b0;
    cyc_m      = '0;
    th_data_m  = '0;
    th_valid_m = 1'b0;
    #1;
    check("rst_con_valid", 32'(con_valid), 32'h0);
    check("rst_th_valid", 32'(tohost_valid), 32'h0);
    check("rst_th_data", tohost_data, 32'h0);
    check("rst_console", dmem_rdata, 32'h0);
    dmem_addr = 16'h8004;
    #1;
    check("rst_cycle", dmem_rdata, 32'h0);
    repeat (n) @(negedge clk);
    dmem_wr_en = 4'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    logic [31:0] c1;
    logic [15:0] a;
    reset_n    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wr_en = '0;
    con_ready  = 1'b0;
    @(negedge clk);
    do_reset(3);

    for (int w = 0; w < 16; w++) cycle(16'(w * 4), $urandom, 4'hF, 1'b0);

    // Byte-lane write and alias read.
    cycle(16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    cycle(16'h0010, 32'h0000_5500, 4'b0010, 1'b0);
    cycle(16'h0010, 32'h0, 4'b0, 1'b0);
    check("ram_lane", obs_rd, 32'hDEAD_55EF);
    cycle(16'h4010, 32'h0, 4'b0, 1'b0);
    check("ram_alias", obs_rd, 32'hDEAD_55EF);

    // Console ordering.
    for (int i = 0; i < 3; i++) cycle(16'h8000, 32'h41 + 32'(i), 4'b0001, 1'b0);
    cycle(16'h8000, 32'h0, 4'b0, 1'b0);
    check("con_count", obs_rd, 32'h3);
    check("con_head", 32'(obs_cd), 32'h41);
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0000, 32'h0, 4'b0, 1'b1);
      check("con_drain", 32'(obs_cd), 32'h41 + 32'(i));
    end
    cycle(16'h0000, 32'h0, 4'b0, 1'b0);
    check("con_empty", 32'(obs_cv), 32'h0);

    // Overflow, push-while-full-with-pop, overflow clear.
    for (int i = 0; i < 9; i++) cycle(16'h8000, 32'h10 + 32'(i), 4'b0001, 1'b0);
    cycle(16'h8000, 32'h0, 4'b0, 1'b0);
    check("full_ovf", obs_rd, 32'h8000_0088);
    cycle(16'h8000, 32'h99, 4'b0001, 1'b1);
    cycle(16'h8000, 32'h0, 4'b0, 1'b0);
    check("full_keep", obs_rd, 32'h8000_0088);
    for (int i = 0; i < 8; i++) begin
      cycle(16'h0000, 32'h0, 4'b0, 1'b1);
      check("ovf_order", 32'(obs_cd), (i < 7) ? 32'h11 + 32'(i) : 32'h99);
    end
    cycle(16'h800C, 32'h1, 4'b0001, 1'b0);
    cycle(16'h8000, 32'h0, 4'b0, 1'b0);
    check("ovf_clr", obs_rd, 32'h0);

    // Tohost mailbox is sticky.
    cycle(16'h8008, 32'h1, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(16'h0000, 32'h0, 4'b0, 1'b0);
      check("tohost_v", 32'(obs_tv), 32'h1);
      check("tohost_d", obs_td, 32'h1);
    end

    // Cycle counter delta, then reset with bytes queued.
    cycle(16'h8004, 32'h0, 4'b0, 1'b0);
    c1 = obs_rd;
    repeat (6) cycle(16'h0000, 32'h0, 4'b0, 1'b0);
    cycle(16'h8004, 32'h0, 4'b0, 1'b0);
    check("cycle_diff", obs_rd - c1, 32'd7);
    for (int i = 0; i < 4; i++) cycle(16'h8000, 32'h60 + 32'(i), 4'b0001, 1'b0);
    do_reset(2);
    cycle(16'h8004, 32'h0, 4'b0, 1'b0);
    check("cyc_after_rst", obs_rd, 32'h0);
    check("cv_after_rst", 32'(obs_cv), 32'h0);
    check("tv_after_rst", 32'(obs_tv), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) < 3) a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      else a = 16'(($urandom_range(0, 1) << 14) | ($urandom_range(0, 15) << 2) |
                    $urandom_range(0, 3));
      cycle(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0,
            1'($urandom_range(0, 1)));
      if (i % 1000 == 999) do_reset(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
